dac_spi_output: RTL and testbench

Serializes the eight 16-bit analog-output words (one per analog_out_sequencer instance, or host values) to eight AD5662-class SPI DACs over a shared SYNC/SCLK and parallel DIN lines. Sits directly downstream of the analog-out sequencers. It is fired once per sample period by a strobe from the main state machine. It captures a coherent snapshot of all eight words and shifts out one 24-bit frame per DAC.

---
 rtl/dac_spi_output.sv | 195 +++++++++++++++++++
 tb/tb_dac_spi_output.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_output.sv
// dac_spi_output
//   Snapshots one 16-bit word per channel on sample_strobe and shifts it out
//   as a 24-bit frame {6'b0, pd_mode, word}, MSB first, to NUM_DAC SPI DACs.
//   The DACs share SYNC/SCLK and each has its own DIN line.
//
// Ports
//   dataclk, reset_n        clock (rising edge), async active-low reset
//   sample_strobe           one-cycle frame request
//   seq_en/seq_data/host_data  per-channel source select and words (16b/ch)
//   pd_mode, shutdown       power-down bits; force MIDSCALE at capture
//   clear_overrun           clears the sticky overrun flag
//   DAC_SYNC/SCLK/DIN       SPI outputs (SYNC active low, SCLK idles high)
//   busy, frame_done, overrun  status
module dac_spi_output #(
  parameter int          NUM_DAC  = 8,
  parameter int          CLK_DIV  = 2,
  parameter logic [15:0] MIDSCALE = 16'h8000
) (
  input  logic                   dataclk,
  input  logic                   reset_n,
  input  logic                   sample_strobe,
  input  logic [NUM_DAC-1:0]     seq_en,
  input  logic [16*NUM_DAC-1:0]  seq_data,
  input  logic [16*NUM_DAC-1:0]  host_data,
  input  logic [1:0]             pd_mode,
  input  logic                   shutdown,
  input  logic                   clear_overrun,
  output logic                   DAC_SYNC,
  output logic                   DAC_SCLK,
  output logic [NUM_DAC-1:0]     DAC_DIN,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic          sync_q, sync_d;
  logic          sclk_q, sclk_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  logic accept, div_end, last_bit, low_end;
  logic lane_load, lane_shift, lane_clr;

  assign accept   = (state_q == S_IDLE) && sample_strobe;
  assign div_end  = (div_q == DIV_LAST);
  assign last_bit = (bit_q == 5'd0);
  // end of the SCLK-low half of the current bit
  assign low_end  = (state_q == S_SHIFT) && div_end && !sclk_q;

  // Lane controls: DIN only moves on the SCLK rising edge (or at capture,
  // where SCLK is already high) so it is stable across the falling edge.
  assign lane_load  = accept;
  assign lane_shift = low_end && !last_bit;
  assign lane_clr   = low_end && last_bit;

  // ---------------- state register ----------------
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sample_strobe)          state_d = S_SHIFT;
      S_SHIFT: if (low_end && last_bit)    state_d = S_GAP;
      S_GAP:   if (div_end)                state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs / datapath ----------------
  always_comb begin
    div_d  = div_q;
    bit_d  = bit_q;
    sync_d = sync_q;
    sclk_d = sclk_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (accept) begin
          sync_d = 1'b0;
          sclk_d = 1'b1;
          busy_d = 1'b1;
          bit_d  = 5'd23;
        end
      end
      S_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (sclk_q) sclk_d = 1'b0;
          else begin
            sclk_d = 1'b1;
            if (last_bit) sync_d = 1'b1;
            else          bit_d  = bit_q - 5'd1;
          end
        end else div_d = div_q + DW'(1);
      end
      S_GAP: begin
        if (div_end) begin
          div_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else div_d = div_q + DW'(1);
      end
      default: begin
        div_d  = '0;
        sync_d = 1'b1;
        sclk_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
    // set has priority over clear
    if (sample_strobe && state_q != S_IDLE) ovr_d = 1'b1;
    else if (clear_overrun)                 ovr_d = 1'b0;
    else                                    ovr_d = ovr_q;
  end

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      bit_q  <= '0;
      sync_q <= 1'b1;
      sclk_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      sync_q <= sync_d;
      sclk_q <= sclk_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  // ---------------- per-lane snapshot shift registers ----------------
  for (genvar g = 0; g < NUM_DAC; g++) begin : g_lane
    logic [15:0] word;
    logic [23:0] frame;
    logic [22:0] sr_q, sr_d;   // bits still to send after the one on DIN
    logic        din_q, din_d;

    always_comb begin
      word  = shutdown ? MIDSCALE
            : (seq_en[g] ? seq_data[16*g +: 16] : host_data[16*g +: 16]);
      frame = {6'b0, pd_mode, word};
      sr_d  = sr_q;
      din_d = din_q;
      if (lane_load) begin
        din_d = frame[23];
        sr_d  = frame[22:0];
      end else if (lane_shift) begin
        din_d = sr_q[22];
        sr_d  = {sr_q[21:0], 1'b0};
      end else if (lane_clr) begin
        din_d = 1'b0;
        sr_d  = '0;
      end
    end

    always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
        sr_q  <= '0;
        din_q <= 1'b0;
      end else begin
        sr_q  <= sr_d;
        din_q <= din_d;
      end
    end

    assign DAC_DIN[g] = din_q;
  end

  assign DAC_SYNC   = sync_q;
  assign DAC_SCLK   = sclk_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_dac_spi_output.sv
// Directed bench for dac_spi_output: a CLK_DIV=2 instance carries most
// scenarios, a CLK_DIV=1 instance shares the inputs for the fast-divider case.
module tb_dac_spi_output;
  localparam int N = 8;

  logic           dataclk = 1'b0;
  logic           reset_n;
  logic           sample_strobe;
  logic [N-1:0]   seq_en;
  logic [16*N-1:0] seq_data, host_data;
  logic [1:0]     pd_mode;
  logic           shutdown, clear_overrun;

  logic           sync0, sclk0, busy0, done0, ovr0;
  logic [N-1:0]   din0;
  logic           sync1, sclk1, busy1, done1, ovr1;
  logic [N-1:0]   din1;

  int n_vec = 0;
  int n_err = 0;

  always #5 dataclk = ~dataclk;

  dac_spi_output #(.NUM_DAC(N), .CLK_DIV(2), .MIDSCALE(16'h8000)) u_dut (
    .dataclk(dataclk), .reset_n(reset_n), .sample_strobe(sample_strobe),
    .seq_en(seq_en), .seq_data(seq_data), .host_data(host_data),
    .pd_mode(pd_mode), .shutdown(shutdown), .clear_overrun(clear_overrun),
    .DAC_SYNC(sync0), .DAC_SCLK(sclk0), .DAC_DIN(din0),
    .busy(busy0), .frame_done(done0), .overrun(ovr0));

  dac_spi_output #(.NUM_DAC(N), .CLK_DIV(1), .MIDSCALE(16'h8000)) u_dut1 (
    .dataclk(dataclk), .reset_n(reset_n), .sample_strobe(sample_strobe),
    .seq_en(seq_en), .seq_data(seq_data), .host_data(host_data),
    .pd_mode(pd_mode), .shutdown(shutdown), .clear_overrun(clear_overrun),
    .DAC_SYNC(sync1), .DAC_SCLK(sclk1), .DAC_DIN(din1),
    .busy(busy1), .frame_done(done1), .overrun(ovr1));

  localparam logic [16*N-1:0] S1 = {16'h1007, 16'h1006, 16'h1005, 16'h1004,
                                    16'h1003, 16'h1002, 16'h1001, 16'h1000};
  localparam logic [16*N-1:0] S2 = {16'h2007, 16'h2006, 16'h2005, 16'h2004,
                                    16'h2003, 16'h2002, 16'h2001, 16'h2000};

  task automatic idle(input int n);
    repeat (n) @(negedge dataclk);
  endtask

  // Fires a strobe at the current negedge (so edge E0 is the next posedge) and
  // records the CLK_DIV=2 instance for samples k=1..99 (sample k lies between
  // edges E0+k-1 and E0+k). Optional injections at sample k act on edge E0+k.
  task automatic capture(input int strb_at, input int clr_at, input int chg_at,
                         input logic [16*N-1:0] chg_seq, input logic chg_shut,
                         output logic [N-1:0][23:0] bits, output int sync_low,
                         output int busy_n, output int done_at,
                         output int falls, output int unstable);
    logic         prev_sclk;
    logic [N-1:0] prev_din;
    bits = '0; sync_low = 0; busy_n = 0; done_at = -1; falls = 0; unstable = 0;
    prev_sclk = 1'b1; prev_din = '0;
    sample_strobe = 1'b1;
    @(negedge dataclk);
    sample_strobe = 1'b0;
    for (int k = 1; k <= 99; k++) begin
      if (!sync0) sync_low++;
      if (busy0) busy_n++;
      if (done0 && done_at < 0) done_at = k - 1;
      if (prev_sclk && !sclk0) begin
        falls++;
        for (int i = 0; i < N; i++) bits[i] = {bits[i][22:0], prev_din[i]};
        if (din0 !== prev_din) unstable++;
      end
      prev_sclk = sclk0;
      prev_din  = din0;
      if (k == chg_at) begin seq_data = chg_seq; shutdown = chg_shut; end
      sample_strobe = (k == strb_at);
      clear_overrun = (k == clr_at);
      if (k < 99) @(negedge dataclk);
    end
    sample_strobe = 1'b0;
    clear_overrun = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; sample_strobe = 1'b0; seq_en = '0; seq_data = '0;
    host_data = '0; pd_mode = '0; shutdown = 1'b0; clear_overrun = 1'b0;
    idle(3);
    n_vec++; if (sync0 !== 1'b1) begin n_err++; $display("FAIL reset_sync got %b exp 1", sync0); end
    n_vec++; if (sclk0 !== 1'b1) begin n_err++; $display("FAIL reset_sclk got %b exp 1", sclk0); end
    n_vec++; if (din0 !== 8'h00) begin n_err++; $display("FAIL reset_din got %h exp 00", din0); end
    n_vec++; if ({busy0, done0, ovr0} !== 3'b000) begin n_err++; $display("FAIL reset_status got %b exp 000", {busy0, done0, ovr0}); end
    n_vec++; if ({sync1, sclk1, busy1} !== 3'b110) begin n_err++; $display("FAIL reset_dut1 got %b exp 110", {sync1, sclk1, busy1}); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_frame;
    logic [N-1:0][23:0] bits, exp;
    int sl, bn, da, fa, un;
    seq_en = 8'hFF; pd_mode = 2'b00; shutdown = 1'b0; host_data = '0;
    seq_data = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                16'h3333, 16'h2222, 16'h1111, 16'hA5C3};
    exp = {24'h007777, 24'h006666, 24'h005555, 24'h004444,
           24'h003333, 24'h002222, 24'h001111, 24'h00A5C3};
    capture(0, 0, 0, seq_data, 1'b0, bits, sl, bn, da, fa, un);
    for (int i = 0; i < N; i++) begin
      n_vec++; if (bits[i] !== exp[i]) begin n_err++; $display("FAIL basic_ch%0d got %h exp %h", i, bits[i], exp[i]); end
    end
    n_vec++; if (sl != 96) begin n_err++; $display("FAIL basic_sync_low got %0d exp 96", sl); end
    n_vec++; if (bn != 98) begin n_err++; $display("FAIL basic_busy got %0d exp 98", bn); end
    n_vec++; if (da != 98) begin n_err++; $display("FAIL basic_done_at got %0d exp 98", da); end
    n_vec++; if (fa != 24) begin n_err++; $display("FAIL basic_falls got %0d exp 24", fa); end
    n_vec++; if (un != 0) begin n_err++; $display("FAIL basic_din_unstable got %0d exp 0", un); end
    n_vec++; if ({sync0, sclk0, busy0, done0} !== 4'b1101) begin n_err++; $display("FAIL basic_end got %b exp 1101", {sync0, sclk0, busy0, done0}); end
    idle(1);
    n_vec++; if ({done0, ovr0} !== 2'b00) begin n_err++; $display("FAIL basic_done_pulse got %b exp 00", {done0, ovr0}); end
    idle(3);
  endtask

  task automatic test_source_mux;
    logic [N-1:0][23:0] bits, exp;
    int sl, bn, da, fa, un;
    seq_en = 8'b0000_0101; pd_mode = 2'b10; shutdown = 1'b0;
    seq_data  = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                 16'h3333, 16'h2222, 16'h1111, 16'h0000};
    host_data = {16'hF007, 16'hF006, 16'hF005, 16'hF004,
                 16'hF003, 16'hF002, 16'hF001, 16'hF000};
    exp = {24'h02F007, 24'h02F006, 24'h02F005, 24'h02F004,
           24'h02F003, 24'h022222, 24'h02F001, 24'h020000};
    // shutdown raised mid-frame must not disturb the frame in flight
    capture(0, 0, 10, seq_data, 1'b1, bits, sl, bn, da, fa, un);
    for (int i = 0; i < N; i++) begin
      n_vec++; if (bits[i] !== exp[i]) begin n_err++; $display("FAIL mux_ch%0d got %h exp %h", i, bits[i], exp[i]); end
    end
    idle(3);
    capture(0, 0, 0, seq_data, 1'b1, bits, sl, bn, da, fa, un);
    for (int i = 0; i < N; i++) begin
      n_vec++; if (bits[i] !== 24'h028000) begin n_err++; $display("FAIL shutdown_ch%0d got %h exp 028000", i, bits[i]); end
    end
    shutdown = 1'b0;
    idle(3);
  endtask

  task automatic test_mid_change;
    logic [N-1:0][23:0] bits;
    int sl, bn, da, fa, un;
    seq_en = 8'hFF; pd_mode = 2'b01; seq_data = S1;
    capture(0, 0, 10, S2, 1'b0, bits, sl, bn, da, fa, un);
    for (int i = 0; i < N; i++) begin
      n_vec++; if (bits[i] !== {8'h01, 16'h1000 + 16'(i)}) begin n_err++; $display("FAIL midchg_cur_ch%0d got %h exp %h", i, bits[i], {8'h01, 16'h1000 + 16'(i)}); end
    end
    idle(3);
    capture(0, 0, 0, S2, 1'b0, bits, sl, bn, da, fa, un);
    for (int i = 0; i < N; i++) begin
      n_vec++; if (bits[i] !== {8'h01, 16'h2000 + 16'(i)}) begin n_err++; $display("FAIL midchg_next_ch%0d got %h exp %h", i, bits[i], {8'h01, 16'h2000 + 16'(i)}); end
    end
    idle(3);
  endtask

  task automatic test_overrun;
    logic [N-1:0][23:0] bits;
    int sl, bn, da, fa, un;
    seq_en = 8'hFF; pd_mode = 2'b00; seq_data = S1;
    // strobe mid-shift: ignored, flagged
    capture(50, 0, 0, S1, 1'b0, bits, sl, bn, da, fa, un);
    n_vec++; if (bits[3] !== 24'h001003) begin n_err++; $display("FAIL ovr50_frame got %h exp 001003", bits[3]); end
    n_vec++; if (da != 98 || bn != 98) begin n_err++; $display("FAIL ovr50_timing got done %0d busy %0d exp 98 98", da, bn); end
    n_vec++; if (ovr0 !== 1'b1) begin n_err++; $display("FAIL ovr50_flag got %b exp 1", ovr0); end
    idle(4);
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL ovr50_no_restart busy got %b exp 0", busy0); end
    clear_overrun = 1'b1; idle(1); clear_overrun = 1'b0;
    n_vec++; if (ovr0 !== 1'b0) begin n_err++; $display("FAIL ovr_clear got %b exp 0", ovr0); end
    idle(2);
    // strobe on the frame_done edge is still rejected
    capture(98, 0, 0, S1, 1'b0, bits, sl, bn, da, fa, un);
    n_vec++; if ({ovr0, busy0} !== 2'b10) begin n_err++; $display("FAIL ovr98 got ovr/busy %b exp 10", {ovr0, busy0}); end
    // one cycle later is accepted (capture strobes on edge E0+99)
    seq_data = S2;
    capture(0, 0, 0, S2, 1'b0, bits, sl, bn, da, fa, un);
    n_vec++; if (bits[5] !== 24'h002005) begin n_err++; $display("FAIL ovr99_frame got %h exp 002005", bits[5]); end
    n_vec++; if (da != 98) begin n_err++; $display("FAIL ovr99_done_at got %0d exp 98", da); end
    n_vec++; if (ovr0 !== 1'b1) begin n_err++; $display("FAIL ovr99_sticky got %b exp 1", ovr0); end
    idle(3);
    // clear and busy strobe together: set wins
    capture(50, 50, 0, S2, 1'b0, bits, sl, bn, da, fa, un);
    n_vec++; if (ovr0 !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins got %b exp 1", ovr0); end
    clear_overrun = 1'b1; idle(1); clear_overrun = 1'b0;
    n_vec++; if (ovr0 !== 1'b0) begin n_err++; $display("FAIL ovr_clear2 got %b exp 0", ovr0); end
    idle(3);
  endtask

  task automatic test_async_reset;
    logic [N-1:0][23:0] bits;
    int sl, bn, da, fa, un;
    seq_en = 8'hFF; pd_mode = 2'b00; seq_data = S1;
    sample_strobe = 1'b1; idle(1); sample_strobe = 1'b0;
    idle(39);
    n_vec++; if ({sync0, busy0} !== 2'b01) begin n_err++; $display("FAIL arst_pre got sync/busy %b exp 01", {sync0, busy0}); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if ({sync0, sclk0, busy0} !== 3'b110) begin n_err++; $display("FAIL arst_ctrl got %b exp 110", {sync0, sclk0, busy0}); end
    n_vec++; if (din0 !== 8'h00) begin n_err++; $display("FAIL arst_din got %h exp 00", din0); end
    idle(1);
    reset_n = 1'b1;
    idle(2);
    seq_data = S2;
    capture(0, 0, 0, S2, 1'b0, bits, sl, bn, da, fa, un);
    for (int i = 0; i < N; i++) begin
      n_vec++; if (bits[i] !== {8'h00, 16'h2000 + 16'(i)}) begin n_err++; $display("FAIL arst_frame_ch%0d got %h exp %h", i, bits[i], {8'h00, 16'h2000 + 16'(i)}); end
    end
    n_vec++; if (da != 98 || sl != 96) begin n_err++; $display("FAIL arst_timing got done %0d sync %0d exp 98 96", da, sl); end
    idle(3);
  endtask

  task automatic test_clkdiv1;
    logic [N-1:0][23:0] bits;
    logic         prev_sclk;
    logic [N-1:0] prev_din;
    int sl = 0, bn = 0, da = -1, fa = 0, un = 0;
    seq_en = 8'hFF; pd_mode = 2'b11; seq_data = S1;
    bits = '0; prev_sclk = 1'b1; prev_din = '0;
    sample_strobe = 1'b1; idle(1); sample_strobe = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (!sync1) sl++;
      if (busy1) bn++;
      if (done1 && da < 0) da = k - 1;
      if (prev_sclk && !sclk1) begin
        fa++;
        for (int i = 0; i < N; i++) bits[i] = {bits[i][22:0], prev_din[i]};
        if (din1 !== prev_din) un++;
      end
      prev_sclk = sclk1;
      prev_din  = din1;
      idle(1);
    end
    n_vec++; if (sl != 48) begin n_err++; $display("FAIL div1_sync_low got %0d exp 48", sl); end
    n_vec++; if (bn != 49) begin n_err++; $display("FAIL div1_busy got %0d exp 49", bn); end
    n_vec++; if (da != 49) begin n_err++; $display("FAIL div1_done_at got %0d exp 49", da); end
    n_vec++; if (fa != 24 || un != 0) begin n_err++; $display("FAIL div1_edges got falls %0d unstable %0d exp 24 0", fa, un); end
    for (int i = 0; i < N; i++) begin
      n_vec++; if (bits[i] !== {8'h03, 16'h1000 + 16'(i)}) begin n_err++; $display("FAIL div1_ch%0d got %h exp %h", i, bits[i], {8'h03, 16'h1000 + 16'(i)}); end
    end
    idle(50);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_source_mux();
    test_mid_change();
    test_overrun();
    test_async_reset();
    test_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
